// File: rtl/uart_wb_arbiter_pkg.sv
// Shared types and constants for the UART Wishbone arbiter.
package uart_wb_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating stall counter; o_expired holds once TIMEOUT_CYCLES stalled cycles are seen.
module wb_timeout_ctr #(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        r_cnt <= '0;
    else if (i_clr)                      r_cnt <= '0;
    else if (i_en && r_cnt != LP_LIMIT)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_expired = (r_cnt == LP_LIMIT);
endmodule

// File: rtl/uart_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the UART macro slave port,
// granting whole bus cycles and aborting stalled accesses with a bus error.
module uart_wb_arbiter
  import uart_wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [SEL_W-1:0] s_sel_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic             s_ack_i,
  input  logic [DAT_W-1:0] s_dat_i,
  output logic [1:0]       grant_o,
  output logic             timeout_o
);
  arb_state_e r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_last, w_last_nxt;
  logic       r_err_first;
  logic       w_own_cyc, w_own_stb, w_busy, w_en, w_expired;

  assign w_own_cyc = (r_owner == M1) ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = (r_owner == M1) ? m1_stb_i : m0_stb_i;
  assign w_busy    = (r_state == BUSY);
  assign w_en      = w_busy && w_own_stb && !s_ack_i;

  wb_timeout_ctr #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk     (wb_clk_i),
    .i_rst_n   (wb_rst_ni),
    .i_clr     (!w_en),
    .i_en      (w_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= IDLE;
      r_owner     <= M0;
      r_last      <= M1;
      r_err_first <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_last      <= w_last_nxt;
      r_err_first <= w_busy && (w_state_nxt == ABORT);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        // On a tie the master that was not served last wins.
        if (m0_cyc_i && m1_cyc_i) begin
          w_owner_nxt = ~r_last;
          w_state_nxt = BUSY;
        end else if (m0_cyc_i) begin
          w_owner_nxt = M0;
          w_state_nxt = BUSY;
        end else if (m1_cyc_i) begin
          w_owner_nxt = M1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!w_own_cyc) begin
          w_last_nxt  = r_owner;
          w_state_nxt = IDLE;
        end else if (w_expired && !s_ack_i) begin
          w_state_nxt = ABORT;
        end
      end
      ABORT: begin
        if (!w_own_cyc) begin
          w_last_nxt  = r_owner;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o  = w_busy && w_own_cyc;
    s_stb_o  = w_busy && w_own_stb;
    s_we_o   = (r_owner == M1) ? m1_we_i  : m0_we_i;
    s_sel_o  = (r_owner == M1) ? m1_sel_i : m0_sel_i;
    s_adr_o  = (r_owner == M1) ? m1_adr_i : m0_adr_i;
    s_dat_o  = (r_owner == M1) ? m1_dat_i : m0_dat_i;
    m0_ack_o = w_busy && (r_owner == M0) && s_ack_i;
    m1_ack_o = w_busy && (r_owner == M1) && s_ack_i;
    m0_err_o = r_err_first && (r_owner == M0);
    m1_err_o = r_err_first && (r_owner == M1);
    m0_dat_o = (w_busy && r_owner == M0) ? s_dat_i : '0;
    m1_dat_o = (w_busy && r_owner == M1) ? s_dat_i : '0;
    grant_o  = (r_state == IDLE) ? 2'b00 : ((r_owner == M1) ? 2'b10 : 2'b01);
    timeout_o = r_err_first;
  end
endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Bench for uart_wb_arbiter: directed scenarios plus randomized masters/slave,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_uart_wb_arbiter;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mc [2];
  logic        ms [2];
  logic        mw [2];
  logic [3:0]  msel [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic        s_ack;
  logic [31:0] s_dat;

  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rd, m1_rd;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wd;
  logic [1:0]  grant;
  logic        tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_wb_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_dat_o(m0_rd),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_dat_o(m1_rd),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wd), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(grant), .timeout_o(tmo)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: ph 0 = nobody owns the bus, 1 = owner being served, 2 = owner's access aborted.
  int   ph;
  logic own, lst, first_abort;
  int   stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 0; own <= 1'b0; lst <= 1'b1; stall <= 0; first_abort <= 1'b0;
    end else begin
      first_abort <= 1'b0;
      if (ph == 0) begin
        if (mc[0] || mc[1]) begin
          own   <= (mc[0] && mc[1]) ? ~lst : mc[1];
          ph    <= 1;
          stall <= 0;
        end
      end else if (ph == 1) begin
        if (!mc[own]) begin
          lst <= own; ph <= 0;
        end else if (stall >= T && !s_ack) begin
          ph <= 2; first_abort <= 1'b1;
        end else begin
          stall <= (ms[own] && !s_ack) ? stall + 1 : 0;
        end
      end else begin
        if (!mc[own]) begin
          lst <= own; ph <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic srv;
    srv = (ph == 1);
    chk("grant",    {30'd0, grant}, (ph == 0) ? 32'd0 : (own ? 32'd2 : 32'd1));
    chk("s_cyc",    {31'd0, s_cyc}, {31'd0, srv && mc[own]});
    chk("s_stb",    {31'd0, s_stb}, {31'd0, srv && ms[own]});
    chk("timeout",  {31'd0, tmo},   {31'd0, first_abort});
    chk("m0_ack",   {31'd0, m0_ack}, {31'd0, srv && !own && s_ack});
    chk("m1_ack",   {31'd0, m1_ack}, {31'd0, srv &&  own && s_ack});
    chk("m0_err",   {31'd0, m0_err}, {31'd0, first_abort && !own});
    chk("m1_err",   {31'd0, m1_err}, {31'd0, first_abort &&  own});
    chk("m0_dat",   m0_rd, (srv && !own) ? s_dat : 32'd0);
    chk("m1_dat",   m1_rd, (srv &&  own) ? s_dat : 32'd0);
    if (srv) begin
      chk("s_we",  {31'd0, s_we}, {31'd0, mw[own]});
      chk("s_sel", {28'd0, s_sel}, {28'd0, msel[own]});
      chk("s_adr", s_adr, madr[own]);
      chk("s_dat", s_wd,  mdat[own]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic we, input logic [31:0] adr, input logic [31:0] dat);
    mc[i] = 1'b1; ms[i] = 1'b1; mw[i] = we; msel[i] = 4'hF; madr[i] = adr; mdat[i] = dat;
  endtask

  task automatic drop(input int i);
    mc[i] = 1'b0; ms[i] = 1'b0;
  endtask

  task automatic new_beat(input int i);
    ms[i] = 1'b1; mw[i] = 1'($urandom); msel[i] = 4'($urandom);
    madr[i] = $urandom; mdat[i] = $urandom;
  endtask

  logic a_s [2];
  logic e_s [2];
  int   p;

  initial begin
    rst_n = 1'b0; s_ack = 1'b0; s_dat = '0;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 0; ms[i] = 0; mw[i] = 0; msel[i] = 0; madr[i] = 0; mdat[i] = 0;
    end
    step(); step();
    s_ack = 1'b1; #1;
    chk("rst grant", {30'd0, grant}, 32'd0);
    chk("rst s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst m0_ack", {31'd0, m0_ack}, 32'd0);
    s_ack = 1'b0;
    step(); rst_n = 1'b1;

    // Single master write, slave acks on the third BUSY cycle.
    step(); req(0, 1'b1, 32'h3000_0000, 32'h41); #1;
    chk("single idle grant", {30'd0, grant}, 32'd0);
    step(); #1;
    chk("single grant", {30'd0, grant}, 32'd1);
    chk("single s_adr", s_adr, 32'h3000_0000);
    chk("single s_dat", s_wd, 32'h41);
    chk("single s_cyc", {31'd0, s_cyc}, 32'd1);
    step(); step(); s_ack = 1'b1; #1;
    chk("single ack", {31'd0, m0_ack}, 32'd1);
    step(); s_ack = 1'b0; drop(0);
    step(); #1;
    chk("single release", {30'd0, grant}, 32'd0);

    // Stall isolation: m1 waits behind an m0 read.
    req(0, 1'b0, 32'h3000_0004, 32'h0);
    step(); req(1, 1'b0, 32'h3000_0008, 32'h0);
    step(); s_ack = 1'b1; s_dat = 32'hDEAD_BEEF; #1;
    chk("iso m0_dat", m0_rd, 32'hDEAD_BEEF);
    chk("iso m1_ack", {31'd0, m1_ack}, 32'd0);
    chk("iso m1_dat", m1_rd, 32'd0);
    step(); s_ack = 1'b0; drop(0);
    step(); #1;
    chk("iso gap", {30'd0, grant}, 32'd0);
    step(); #1;
    chk("iso m1 grant", {30'd0, grant}, 32'd2);

    // Block transfer: three back-to-back beats for m1.
    for (int k = 0; k < 3; k++) begin
      madr[1] = 32'h100 + 32'(k * 4); s_ack = 1'b1; #1;
      chk("blk grant", {30'd0, grant}, 32'd2);
      chk("blk ack", {31'd0, m1_ack}, 32'd1);
      chk("blk adr", s_adr, 32'h100 + 32'(k * 4));
      step();
    end
    s_ack = 1'b0; drop(1);
    step();

    // Timeout: slave never acks; err on the 6th BUSY/ABORT cycle.
    req(0, 1'b1, 32'h3000_000C, 32'h55);
    for (int k = 0; k < 7; k++) begin
      step();
      if (k == 6) s_ack = 1'b1;
      #1;
      chk("tmo err", {31'd0, m0_err}, {31'd0, k == 5});
      chk("tmo pulse", {31'd0, tmo}, {31'd0, k == 5});
      chk("tmo s_cyc", {31'd0, s_cyc}, {31'd0, k < 5});
      if (k == 6) chk("tmo late ack", {31'd0, m0_ack}, 32'd0);
    end
    step(); s_ack = 1'b0; drop(0);
    step();

    // Asynchronous reset while m1 owns the bus.
    req(1, 1'b0, 32'h3000_0010, 32'h0);
    step(); #1;
    chk("rstm grant", {30'd0, grant}, 32'd2);
    s_ack = 1'b1; #1; rst_n = 1'b0; #1;
    chk("rstm grant0", {30'd0, grant}, 32'd0);
    chk("rstm s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rstm s_stb", {31'd0, s_stb}, 32'd0);
    chk("rstm m1_ack", {31'd0, m1_ack}, 32'd0);
    s_ack = 1'b0;
    step(); step(); rst_n = 1'b1; req(0, 1'b0, 32'h3000_0014, 32'h0);
    step(); #1;
    chk("tie m0 first", {30'd0, grant}, 32'd1);
    s_ack = 1'b1;
    step(); s_ack = 1'b0; drop(0);
    step(); req(0, 1'b0, 32'h3000_0018, 32'h0); #1;
    chk("tie gap", {31'd0, s_cyc}, 32'd0);
    step(); #1;
    chk("tie repeat m1", {30'd0, grant}, 32'd2);
    drop(1);
    step(); step(); #1;
    chk("tie then m0", {30'd0, grant}, 32'd1);
    drop(0);
    step(); step();

    // Randomized masters and slave; ack probability varies by epoch.
    p = 50;
    for (int cy = 0; cy < 4000; cy++) begin
      if (cy % 60 == 0) begin
        case ($urandom_range(3))
          0: p = 0;
          1: p = 25;
          2: p = 60;
          default: p = 95;
        endcase
      end
      @(negedge clk);
      a_s[0] = m0_ack; a_s[1] = m1_ack; e_s[0] = m0_err; e_s[1] = m1_err;
      @(posedge clk); #1;
      s_ack = ($urandom_range(99) < p);
      s_dat = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (!mc[i]) begin
          if ($urandom_range(3) == 0) begin mc[i] = 1'b1; new_beat(i); end
        end else if (e_s[i]) begin
          drop(i);
        end else if (a_s[i] && ms[i]) begin
          case ($urandom_range(2))
            0: new_beat(i);
            1: ms[i] = 1'b0;
            default: drop(i);
          endcase
        end else if (!ms[i]) begin
          if ($urandom_range(1) == 0) new_beat(i);
          else if ($urandom_range(3) == 0) drop(i);
        end
      end
    end
    drop(0); drop(1); s_ack = 1'b0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
